// File: rtl/vlsu_load_burst_scheduler_pkg.sv
// Shared VLSU definitions: bus geometry, AXI constants and the per-burst
// descriptor passed from the burst calculator to the scheduler.
package vlsu_load_burst_scheduler_pkg;

    localparam int VLSU_AXI_DATA_WIDTH = 128;
    localparam int VLSU_AXI_ADDR_WIDTH = 64;
    localparam int BEAT_BYTES          = VLSU_AXI_DATA_WIDTH / 8;
    localparam int OFF_WIDTH           = $clog2(BEAT_BYTES);

    // AXI bursts must not cross a 4KB page.
    localparam int PAGE_BYTES = 4096;
    localparam int PAGE_WIDTH = $clog2(PAGE_BYTES);

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    // One AXI burst plus the byte window the load unit must keep from it.
    // Field widths follow the package bus geometry above.
    typedef struct packed {
        logic [VLSU_AXI_ADDR_WIDTH-1:0] addr;
        logic [7:0]                     len;
        logic [OFF_WIDTH-1:0]           start_off;
        logic [OFF_WIDTH-1:0]           end_off;
        logic                           last;
    } burst_info_t;

endpackage

// File: rtl/vlsu_burst_calc.sv
// Pure combinational burst sizing: given the current address and remaining
// byte count, picks the largest chunk that fits the page, the burst-length
// limit and the request, and derives the AR fields and byte window.
module vlsu_burst_calc
    import vlsu_load_burst_scheduler_pkg::*;
#(
    parameter int AxiAddrWidth = VLSU_AXI_ADDR_WIDTH,
    parameter int LenWidth     = 32,
    parameter int MaxBurstLen  = 256
) (
    input  logic [AxiAddrWidth-1:0] cur_addr,
    input  logic [LenWidth-1:0]     remaining,
    output burst_info_t             info,
    output logic [LenWidth-1:0]     chunk
);

    // One extra bit so that page/burst byte counts never wrap.
    localparam int CalcWidth = LenWidth + 1;
    localparam logic [CalcWidth-1:0]    PageSize      = CalcWidth'(PAGE_BYTES);
    localparam logic [CalcWidth-1:0]    MaxBurstBytes = CalcWidth'(MaxBurstLen * BEAT_BYTES);
    localparam logic [CalcWidth-1:0]    BeatRound     = CalcWidth'(BEAT_BYTES - 1);
    localparam logic [CalcWidth-1:0]    CalcOne       = CalcWidth'(1);
    localparam logic [OFF_WIDTH-1:0]    OffOne        = OFF_WIDTH'(1);
    localparam logic [AxiAddrWidth-1:0] BeatMask      = AxiAddrWidth'(BEAT_BYTES - 1);

    logic [OFF_WIDTH-1:0] addr_off;
    logic [CalcWidth-1:0] off;
    logic [CalcWidth-1:0] to_page;
    logic [CalcWidth-1:0] max_bytes;
    logic [CalcWidth-1:0] rem_ext;
    logic [CalcWidth-1:0] chunk_ext;
    logic [CalcWidth-1:0] beats;

    // chunk = min(remaining, bytes to page end, burst capacity from this offset)
    always_comb begin
        addr_off  = cur_addr[OFF_WIDTH-1:0];
        off       = CalcWidth'(addr_off);
        to_page   = PageSize - CalcWidth'(cur_addr[PAGE_WIDTH-1:0]);
        max_bytes = MaxBurstBytes - off;
        rem_ext   = CalcWidth'(remaining);
        chunk_ext = rem_ext;
        if (to_page < chunk_ext) begin
            chunk_ext = to_page;
        end
        if (max_bytes < chunk_ext) begin
            chunk_ext = max_bytes;
        end
        beats          = (off + chunk_ext + BeatRound) >> OFF_WIDTH;
        info.addr      = cur_addr & ~BeatMask;
        info.len       = 8'(beats - CalcOne);
        info.start_off = addr_off;
        info.end_off   = addr_off + chunk_ext[OFF_WIDTH-1:0] - OffOne;
        info.last      = (chunk_ext == rem_ext);
        chunk          = chunk_ext[LenWidth-1:0];
    end

endmodule

// File: rtl/vlsu_load_burst_scheduler.sv
// Splits a unit-stride load request into AXI INCR read bursts. Each burst is
// offered on the AR channel and, independently, as a transaction-control
// record to the load unit; the burst retires once both have handshaken.
module vlsu_load_burst_scheduler
    import vlsu_load_burst_scheduler_pkg::*;
#(
    parameter int AxiDataWidth   = VLSU_AXI_DATA_WIDTH,
    parameter int AxiAddrWidth   = VLSU_AXI_ADDR_WIDTH,
    parameter int LenWidth       = 32,
    parameter int MaxBurstLen    = 256,
    parameter int MaxOutstanding = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              req_valid_i,
    output logic                              req_ready_o,
    input  logic [AxiAddrWidth-1:0]           req_addr_i,
    input  logic [LenWidth-1:0]               req_bytes_i,
    output logic                              ar_valid_o,
    input  logic                              ar_ready_i,
    output logic [AxiAddrWidth-1:0]           ar_addr_o,
    output logic [7:0]                        ar_len_o,
    output logic [2:0]                        ar_size_o,
    output logic [1:0]                        ar_burst_o,
    output logic                              txn_valid_o,
    input  logic                              txn_ready_i,
    output logic [$clog2(AxiDataWidth/8)-1:0] txn_start_o,
    output logic [$clog2(AxiDataWidth/8)-1:0] txn_end_o,
    output logic                              txn_last_o,
    input  logic                              r_done_i,
    output logic                              busy_o
);

    localparam int CntWidth = $clog2(MaxOutstanding + 1);
    localparam logic [CntWidth-1:0] CntMax = CntWidth'(MaxOutstanding);
    localparam logic [CntWidth-1:0] CntOne = CntWidth'(1);

    typedef enum logic {IDLE, ISSUE} state_t;

    state_t                  state_reg, state_next;
    logic [AxiAddrWidth-1:0] cur_addr_reg, cur_addr_next;
    logic [LenWidth-1:0]     remaining_reg, remaining_next;
    logic [CntWidth-1:0]     outstanding_reg, outstanding_next;
    logic                    ar_done_reg, ar_done_next;
    logic                    txn_done_reg, txn_done_next;
    logic                    req_ready_reg, req_ready_next;
    logic                    ar_valid_reg, ar_valid_next;
    logic                    txn_valid_reg, txn_valid_next;
    logic                    busy_reg, busy_next;

    burst_info_t         info;
    logic [LenWidth-1:0] chunk;

    logic req_fire;
    logic ar_fire;
    logic txn_fire;

    vlsu_burst_calc #(
        .AxiAddrWidth (AxiAddrWidth),
        .LenWidth     (LenWidth),
        .MaxBurstLen  (MaxBurstLen)
    ) u_burst_calc (
        .cur_addr  (cur_addr_reg),
        .remaining (remaining_reg),
        .info      (info),
        .chunk     (chunk)
    );

    assign req_fire = req_ready_reg & req_valid_i;
    assign ar_fire  = ar_valid_reg & ar_ready_i;
    assign txn_fire = txn_valid_reg & txn_ready_i;

    // Next-state: request capture, burst retirement, outstanding tracking, and
    // the handshake/status flags derived from the next register values.
    always_comb begin
        state_next       = state_reg;
        cur_addr_next    = cur_addr_reg;
        remaining_next   = remaining_reg;
        ar_done_next     = ar_done_reg | ar_fire;
        txn_done_next    = txn_done_reg | txn_fire;
        outstanding_next = outstanding_reg;
        case (state_reg)
            IDLE: begin
                // Zero-byte requests are consumed without producing a burst.
                if (req_fire && (req_bytes_i != '0)) begin
                    state_next     = ISSUE;
                    cur_addr_next  = req_addr_i;
                    remaining_next = req_bytes_i;
                    ar_done_next   = 1'b0;
                    txn_done_next  = 1'b0;
                end
            end
            ISSUE: begin
                if (ar_done_next && txn_done_next) begin
                    ar_done_next   = 1'b0;
                    txn_done_next  = 1'b0;
                    cur_addr_next  = cur_addr_reg + AxiAddrWidth'(chunk);
                    remaining_next = remaining_reg - chunk;
                    if (info.last) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        // A late r_done with nothing outstanding is ignored rather than wrapping.
        if (ar_fire && !r_done_i) begin
            outstanding_next = outstanding_reg + CntOne;
        end else if (!ar_fire && r_done_i && (outstanding_reg != '0)) begin
            outstanding_next = outstanding_reg - CntOne;
        end
        ar_valid_next  = (state_next == ISSUE) && !ar_done_next && (outstanding_next < CntMax);
        txn_valid_next = (state_next == ISSUE) && !txn_done_next;
        req_ready_next = (state_next == IDLE);
        busy_next      = (state_next != IDLE) || (outstanding_next != '0);
    end

    // Scheduler state and registered handshake/status outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg       <= IDLE;
            cur_addr_reg    <= '0;
            remaining_reg   <= '0;
            outstanding_reg <= '0;
            ar_done_reg     <= 1'b0;
            txn_done_reg    <= 1'b0;
            req_ready_reg   <= 1'b1;
            ar_valid_reg    <= 1'b0;
            txn_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cur_addr_reg    <= cur_addr_next;
            remaining_reg   <= remaining_next;
            outstanding_reg <= outstanding_next;
            ar_done_reg     <= ar_done_next;
            txn_done_reg    <= txn_done_next;
            req_ready_reg   <= req_ready_next;
            ar_valid_reg    <= ar_valid_next;
            txn_valid_reg   <= txn_valid_next;
            busy_reg        <= busy_next;
        end
    end

    assign req_ready_o = req_ready_reg;
    assign ar_valid_o  = ar_valid_reg;
    assign txn_valid_o = txn_valid_reg;
    assign busy_o      = busy_reg;
    assign ar_size_o   = 3'($clog2(AxiDataWidth / 8));
    assign ar_burst_o  = AXI_BURST_INCR;

    // Payload only changes on burst retirement; it reads as zero while idle.
    assign ar_addr_o   = (state_reg == ISSUE) ? info.addr      : '0;
    assign ar_len_o    = (state_reg == ISSUE) ? info.len       : '0;
    assign txn_start_o = (state_reg == ISSUE) ? info.start_off : '0;
    assign txn_end_o   = (state_reg == ISSUE) ? info.end_off   : '0;
    assign txn_last_o  = (state_reg == ISSUE) ? info.last      : 1'b0;

endmodule

// File: tb/tb_vlsu_load_burst_scheduler.sv
// Scoreboard bench for the load burst scheduler: requests push expected
// bursts, an independent monitor pops and compares on every handshake.
module tb_vlsu_load_burst_scheduler;

    localparam int MAX_OUT = 2;

    logic        clk_i       = 1'b0;
    logic        rst_i       = 1'b1;
    logic        req_valid_i = 1'b0;
    logic [63:0] req_addr_i  = '0;
    logic [31:0] req_bytes_i = '0;
    logic        ar_ready_i  = 1'b0;
    logic        txn_ready_i = 1'b0;
    logic        r_done_i    = 1'b0;
    logic        req_ready_o;
    logic        ar_valid_o;
    logic [63:0] ar_addr_o;
    logic [7:0]  ar_len_o;
    logic [2:0]  ar_size_o;
    logic [1:0]  ar_burst_o;
    logic        txn_valid_o;
    logic [3:0]  txn_start_o;
    logic [3:0]  txn_end_o;
    logic        txn_last_o;
    logic        busy_o;

    always #5 clk_i = ~clk_i;

    vlsu_load_burst_scheduler #(.MaxOutstanding(MAX_OUT)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_addr_i  (req_addr_i),
        .req_bytes_i (req_bytes_i),
        .ar_valid_o  (ar_valid_o),
        .ar_ready_i  (ar_ready_i),
        .ar_addr_o   (ar_addr_o),
        .ar_len_o    (ar_len_o),
        .ar_size_o   (ar_size_o),
        .ar_burst_o  (ar_burst_o),
        .txn_valid_o (txn_valid_o),
        .txn_ready_i (txn_ready_i),
        .txn_start_o (txn_start_o),
        .txn_end_o   (txn_end_o),
        .txn_last_o  (txn_last_o),
        .r_done_i    (r_done_i),
        .busy_o      (busy_o)
    );

    typedef struct {logic [63:0] addr; logic [7:0] len;} ar_exp_t;
    typedef struct {logic [3:0] start; logic [3:0] fin; logic last;} txn_exp_t;

    ar_exp_t  ar_q[$];
    txn_exp_t txn_q[$];
    int total = 0;
    int bad = 0;
    int out_model = 0;
    bit auto_mode = 1'b1;
    bit m_ar_ready = 1'b0;
    bit m_txn_ready = 1'b0;
    bit m_r_done = 1'b0;

    task automatic check(input string name, input longint unsigned got, input longint unsigned want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Reference: walk the request in page/burst sized chunks with plain arithmetic.
    function automatic void model_push(input logic [63:0] a, input logic [31:0] n);
        longint unsigned addr = a;
        longint unsigned rem = n;
        longint unsigned off, to_page, max_b, chunk, beats;
        ar_exp_t  ea;
        txn_exp_t et;
        while (rem != 0) begin
            off     = addr % 16;
            to_page = 4096 - (addr % 4096);
            max_b   = 256 * 16 - off;
            chunk   = rem;
            if (to_page < chunk) chunk = to_page;
            if (max_b < chunk) chunk = max_b;
            beats    = (off + chunk + 15) / 16;
            ea.addr  = addr - off;
            ea.len   = 8'(beats - 1);
            et.start = 4'(off);
            et.fin   = 4'((addr + chunk - 1) % 16);
            et.last  = (chunk == rem);
            ar_q.push_back(ea);
            txn_q.push_back(et);
            addr += chunk;
            rem  -= chunk;
        end
    endfunction

    // Ready/r_done driver: random when in auto mode, otherwise the manual values.
    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (auto_mode) begin
                ar_ready_i  = ($urandom_range(0, 3) != 0);
                txn_ready_i = ($urandom_range(0, 3) != 0);
                r_done_i    = (out_model > 0) && ($urandom_range(0, 2) == 0);
            end else begin
                ar_ready_i  = m_ar_ready;
                txn_ready_i = m_txn_ready;
                r_done_i    = m_r_done;
            end
        end
    end

    // Monitor: compares every handshake against the scoreboard, checks payload
    // hold while stalled and the outstanding limit.
    initial begin : monitor
        bit       ar_hold;
        bit       txn_hold;
        ar_exp_t  ar_held;
        txn_exp_t txn_held;
        ar_exp_t  ea;
        txn_exp_t et;
        bit       ar_f;
        ar_hold  = 1'b0;
        txn_hold = 1'b0;
        forever begin
            @(negedge clk_i);
            if (rst_i) begin
                out_model = 0;
                ar_hold   = 1'b0;
                txn_hold  = 1'b0;
            end else begin
                if (ar_hold) begin
                    check("ar_hold_valid", ar_valid_o, 1);
                    check("ar_hold_addr", ar_addr_o, ar_held.addr);
                    check("ar_hold_len", ar_len_o, ar_held.len);
                end
                if (txn_hold) begin
                    check("txn_hold_valid", txn_valid_o, 1);
                    check("txn_hold_start", txn_start_o, txn_held.start);
                    check("txn_hold_end", txn_end_o, txn_held.fin);
                    check("txn_hold_last", txn_last_o, txn_held.last);
                end
                if (out_model >= MAX_OUT) check("ar_throttle", ar_valid_o, 0);
                ar_f = ar_valid_o && ar_ready_i;
                if (ar_f) begin
                    $display("ar  addr=%h len=%0d", ar_addr_o, ar_len_o);
                    if (ar_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ar_extra got=addr %h want=no burst", ar_addr_o);
                    end else begin
                        ea = ar_q.pop_front();
                        check("ar_addr", ar_addr_o, ea.addr);
                        check("ar_len", ar_len_o, ea.len);
                        check("ar_size", ar_size_o, 4);
                        check("ar_burst", ar_burst_o, 1);
                    end
                end
                if (txn_valid_o && txn_ready_i) begin
                    $display("txn start=%0d end=%0d last=%0d", txn_start_o, txn_end_o, txn_last_o);
                    if (txn_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL txn_extra got=start %0d want=no record", txn_start_o);
                    end else begin
                        et = txn_q.pop_front();
                        check("txn_start", txn_start_o, et.start);
                        check("txn_end", txn_end_o, et.fin);
                        check("txn_last", txn_last_o, et.last);
                    end
                end
                ar_hold       = ar_valid_o && !ar_ready_i;
                ar_held.addr  = ar_addr_o;
                ar_held.len   = ar_len_o;
                txn_hold      = txn_valid_o && !txn_ready_i;
                txn_held.start = txn_start_o;
                txn_held.fin  = txn_end_o;
                txn_held.last = txn_last_o;
                if (ar_f && !r_done_i) out_model++;
                else if (!ar_f && r_done_i && out_model > 0) out_model--;
            end
        end
    end

    // Issue one request; returns at the sample point of the cycle after acceptance.
    task automatic send_req(input logic [63:0] a, input logic [31:0] n);
        int waited = 0;
        bit ok = 1'b0;
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b1;
        req_addr_i  = a;
        req_bytes_i = n;
        while (!ok) begin
            @(negedge clk_i);
            if (req_ready_o) ok = 1'b1;
            else begin
                waited++;
                if (waited > 5000) break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL req_accept got=timeout want=accept");
            req_valid_i = 1'b0;
            return;
        end
        model_push(a, n);
        $display("req addr=%h bytes=%0d", a, n);
        @(posedge clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        check("req_ready_after_accept", req_ready_o, (n == 0));
        check("txn_first_latency", txn_valid_o, (n != 0));
    endtask

    task automatic wait_drain();
        int waited = 0;
        @(posedge clk_i);
        #1;
        auto_mode = 1'b1;
        while ((ar_q.size() != 0 || txn_q.size() != 0 || out_model != 0 || !req_ready_o) && waited < 5000) begin
            @(negedge clk_i);
            waited++;
        end
        check("drain_in_time", (waited < 5000), 1);
        @(negedge clk_i);
        check("busy_when_idle", busy_o, 0);
    endtask

    task automatic set_manual(input bit ar_r, input bit txn_r);
        @(posedge clk_i);
        #1;
        auto_mode   = 1'b0;
        m_ar_ready  = ar_r;
        m_txn_ready = txn_r;
        m_r_done    = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] a;
        logic [31:0] n;
        int kind;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_req_ready", req_ready_o, 1);
        check("rst_ar_valid", ar_valid_o, 0);
        check("rst_txn_valid", txn_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ar_addr", ar_addr_o, 0);
        check("rst_ar_len", ar_len_o, 0);
        check("rst_txn_end", txn_end_o, 0);
        check("rst_txn_last", txn_last_o, 0);

        // Directed cases under random backpressure.
        send_req(64'h1000, 64);
        send_req(64'h1003, 20);
        send_req(64'h0FF8, 32);
        send_req(64'h0, 8192);
        send_req(64'h1000, 0);
        wait_drain();

        // AR accepted immediately, txn stalled three cycles.
        set_manual(1'b1, 1'b0);
        send_req(64'h0FF8, 32);
        check("stall_ar_first", ar_valid_o, 1);
        @(negedge clk_i);
        check("stall_ar_dropped", ar_valid_o, 0);
        check("stall_txn_held", txn_valid_o, 1);
        @(negedge clk_i);
        check("stall_ar_dropped2", ar_valid_o, 0);
        @(posedge clk_i);
        #1;
        m_txn_ready = 1'b1;
        @(negedge clk_i);
        check("stall_ar_before_txn", ar_valid_o, 0);
        @(negedge clk_i);
        check("stall_next_ar", ar_valid_o, 1);
        check("stall_next_txn", txn_valid_o, 1);
        @(negedge clk_i);
        check("stall_req_ready_after", req_ready_o, 1);
        wait_drain();

        // Outstanding limit with no R completions.
        set_manual(1'b1, 1'b1);
        send_req(64'h0, 12288);
        check("thr_ar1", ar_valid_o, 1);
        @(negedge clk_i);
        check("thr_ar2", ar_valid_o, 1);
        @(negedge clk_i);
        check("thr_ar3_blocked", ar_valid_o, 0);
        check("thr_txn3", txn_valid_o, 1);
        @(negedge clk_i);
        check("thr_ar3_still", ar_valid_o, 0);
        check("thr_txn3_done", txn_valid_o, 0);
        @(posedge clk_i);
        #1;
        m_r_done = 1'b1;
        @(negedge clk_i);
        check("thr_ar_during_rdone", ar_valid_o, 0);
        @(posedge clk_i);
        #1;
        m_r_done = 1'b0;
        @(negedge clk_i);
        check("thr_ar_after_rdone", ar_valid_o, 1);
        wait_drain();

        // Randomised requests, including page-end addresses and empty requests.
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 4);
            a = {1'b0, 31'($urandom), 32'($urandom)};
            case (kind)
                0: n = 0;
                1: n = $urandom_range(1, 64);
                2: n = $urandom_range(1, 700);
                3: n = $urandom_range(3000, 9000);
                default: begin
                    a[11:0] = 12'hFF0 + 12'($urandom_range(0, 15));
                    n = $urandom_range(1, 64);
                end
            endcase
            send_req(a, n);
        end
        wait_drain();

        // Reset in the middle of a long request.
        send_req(64'h2_0000, 20000);
        repeat (6) @(negedge clk_i);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(negedge clk_i);
        ar_q.delete();
        txn_q.delete();
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        check("midrst_ar_valid", ar_valid_o, 0);
        check("midrst_txn_valid", txn_valid_o, 0);
        check("midrst_busy", busy_o, 0);
        check("midrst_req_ready", req_ready_o, 1);
        send_req(64'h1000, 64);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vlsu_load_burst_scheduler.md
Name: vlsu_load_burst_scheduler

Overview:
- Sequences the vector load datapath. Splits one unit-stride load request (base byte address plus byte count) into AXI4 INCR read bursts.
- For each burst, issues the AR beat and the matching per-burst transaction-control record consumed by the sequential load stage.
- Respects AXI 4KB boundaries, the maximum burst length and an outstanding-burst limit. Sits between the VLSU request decoder and the AXI AR channel and load unit.

Parameters:
- AxiDataWidth, 128, bus width in bits; B = AxiDataWidth/8 bytes per beat, power of two.
- AxiAddrWidth, 64, address width.
- LenWidth, 32, width of the request byte count.
- MaxBurstLen, 256, max beats per burst (1..256).
- MaxOutstanding, 8, max AR-issued bursts whose R last beat has not returned.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- req_valid_i  in  1  load request valid
- req_ready_o  out  1  request accepted when valid&ready
- req_addr_i  in  AxiAddrWidth  base byte address
- req_bytes_i  in  LenWidth  total bytes
- ar_valid_o  out  1  AR valid
- ar_ready_i  in  1  AR ready
- ar_addr_o  out  AxiAddrWidth  beat-aligned burst address
- ar_len_o  out  8  beats-1
- ar_size_o  out  3  log2(B)
- ar_burst_o  out  2  constant 2'b01 (INCR)
- txn_valid_o  out  1  transaction-control valid
- txn_ready_i  in  1  transaction-control ready
- txn_start_o  out  log2(B)  first valid byte offset in first beat
- txn_end_o  out  log2(B)  last valid byte offset in last beat
- txn_last_o  out  1  final burst of the request
- r_done_i  in  1  pulse: R handshake with rlast
- busy_o  out  1  state != IDLE or outstanding != 0

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset: state=IDLE, cur_addr=0, remaining=0, outstanding=0, ar_done=txn_done=0. Outputs: req_ready_o=1, ar_valid_o=0, txn_valid_o=0, busy_o=0. All other outputs 0.
- FSM has two states, IDLE and ISSUE.
- IDLE: req_ready_o=1.
  - On accept with req_bytes_i != 0: latch cur_addr and remaining, go to ISSUE.
  - On accept with req_bytes_i == 0: the request is consumed and dropped; stay IDLE.
- ISSUE: req_ready_o=0. The burst is computed combinationally from registers:
  - off = cur_addr mod B
  - to4k = 4096 - (cur_addr mod 4096)
  - maxb = MaxBurstLen*B - off
  - chunk = min(remaining, to4k, maxb)
  - beats = ceil((off+chunk)/B)
  - ar_addr_o = cur_addr & ~(B-1), ar_len_o = beats-1
  - txn_start_o = off, txn_end_o = (cur_addr+chunk-1) mod B
  - txn_last_o = (chunk == remaining)
  - Intermediate arithmetic uses LenWidth+1 bits, with no overflow.
- ar_valid_o = ISSUE & !ar_done & (outstanding < MaxOutstanding).
- txn_valid_o = ISSUE & !txn_done.
- The two channels handshake independently. A done flag sets on its channel's handshake. Once valid is raised, payload is held stable until the handshake.
- Burst completes in the cycle where both channels are done, counting handshakes in that cycle. Then:
  - clear both flags, cur_addr += chunk, remaining -= chunk;
  - if txn_last_o, go to IDLE; else stay in ISSUE, with the next burst valid the following cycle (no bubble).
- Latency: request accepted in cycle N gives first ar_valid_o/txn_valid_o in N+1, unless throttled by the outstanding limit.
- outstanding: +1 on AR handshake, -1 on r_done_i, unchanged if both occur in the same cycle. r_done_i at outstanding==0 is a protocol error and the counter saturates at 0. At MaxOutstanding, ar_valid_o stays low and txn_valid_o may still handshake.
- The next request may be accepted while earlier bursts are still outstanding.
- Reset mid-operation: the in-flight request is abandoned and all state returns to reset values next cycle.

Decomposition:
- Shared VLSU package: burst-info struct {addr, len, start, end, last}, AXI_BURST_INCR, the 4KB page constant, and a clog2-derived offset width.
- One natural sub-module: vlsu_burst_calc, the pure combinational chunk/beats/offset computation, so it can be unit-tested exhaustively.

Test Plan:
- B=16. addr 0x1000, bytes 64 -> one burst: ar_addr 0x1000, len 3, size 4, start 0, end 15, last 1.
- addr 0x1003, bytes 20 -> ar_addr 0x1000, len 1, start 3, end 6, last 1; req_ready_o high the cycle after completion.
- addr 0x0FF8, bytes 32 -> burst 1: 0x0FF0, len 0, start 8, end 15, last 0. Burst 2: 0x1000, len 1, start 0, end 7, last 1, back-to-back.
- addr 0x0, bytes 8192, MaxBurstLen 256 -> bursts at 0x0 and 0x1000, each len 255; last 0 then 1.
- Hold ar_ready=1 and txn_ready=0 for 3 cycles -> single AR handshake, ar_valid drops, txn payload stable; the next burst appears only after the txn handshake.
- MaxOutstanding=2 with r_done_i held low -> third AR held low while txn still handshakes. A single r_done_i pulse gives AR valid next cycle. Asserting rst_i mid-request -> all valids 0 and busy_o=0 the following cycle.
